// File: rtl/axis_pkt_source_if.sv
// AXI4-Stream link between a packet source and its sink.
//   tdata  : stream data, DATA_WIDTH bits (master -> slave)
//   tvalid : beat valid (master -> slave)
//   tlast  : final beat of the packet (master -> slave)
//   tready : slave can accept the beat (slave -> master)
interface axis_pkt_source_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_pkt_source.sv
// AXI4-Stream packet source. A start command emits num_pkts packets of
// pkt_len beats each; data increments by one per transferred beat starting
// at seed, with an optional gap of idle cycles between packets.
//   clk, reset_n        : clock, asynchronous active-low reset
//   start               : command strobe, honoured only when idle
//   pkt_len, num_pkts   : beats per packet / packets per command (0 = ignore)
//   gap                 : idle cycles between packets of one command
//   seed                : data of the first beat of the command
//   axis                : stream master port (tdata/tvalid/tlast, tready)
//   busy, done          : command in progress / one-cycle completion pulse
//   pkt_count           : packets completed since reset, wrapping
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a valid start command
// ST_SEND | presenting beats (tvalid=1) until the final packet's last beat
// ST_GAP  | tvalid=0 between packets, gap_cnt_q counting down to one
module axis_pkt_source #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [7:0]            pkt_len,
  input  logic [7:0]            num_pkts,
  input  logic [3:0]            gap,
  input  logic [DATA_WIDTH-1:0] seed,
  axis_pkt_source_if.master     axis,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           pkt_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [15:0]           pkt_count_q, pkt_count_d;
  logic [7:0]            beat_q, beat_d;
  logic [7:0]            pkts_left_q, pkts_left_d;
  logic [3:0]            gap_cnt_q, gap_cnt_d;
  logic [7:0]            len_q, len_d;
  logic [3:0]            gap_q, gap_d;
  logic                  xfer;

  assign xfer = tvalid_q && axis.tready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pkt_count_q <= 16'd0;
      beat_q      <= 8'd0;
      pkts_left_q <= 8'd0;
      gap_cnt_q   <= 4'd0;
      len_q       <= 8'd0;
      gap_q       <= 4'd0;
    end else begin
      state_q     <= state_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pkt_count_q <= pkt_count_d;
      beat_q      <= beat_d;
      pkts_left_q <= pkts_left_d;
      gap_cnt_q   <= gap_cnt_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pkt_count_d = pkt_count_q;
    beat_d      = beat_q;
    pkts_left_d = pkts_left_q;
    gap_cnt_d   = gap_cnt_q;
    len_d       = len_q;
    gap_d       = gap_q;

    case (state_q)
      ST_IDLE: begin
        // done_q blocks a start sampled in the completion cycle itself
        if (start && !done_q && (pkt_len != 8'd0) && (num_pkts != 8'd0)) begin
          len_d       = pkt_len;
          pkts_left_d = num_pkts;
          gap_d       = gap;
          tdata_d     = seed;
          tvalid_d    = 1'b1;
          tlast_d     = (pkt_len == 8'd1);
          busy_d      = 1'b1;
          beat_d      = 8'd1;
          state_d     = ST_SEND;
        end
      end

      ST_SEND: begin
        if (xfer) begin
          tdata_d = tdata_q + DATA_WIDTH'(1);
          if (tlast_q) begin
            pkt_count_d = pkt_count_q + 16'd1;
            beat_d      = 8'd1;
            if (pkts_left_q == 8'd1) begin
              pkts_left_d = 8'd0;
              tvalid_d    = 1'b0;
              tlast_d     = 1'b0;
              busy_d      = 1'b0;
              done_d      = 1'b1;
              state_d     = ST_IDLE;
            end else begin
              pkts_left_d = pkts_left_q - 8'd1;
              if (gap_q == 4'd0) begin
                tlast_d = (len_q == 8'd1);
              end else begin
                tvalid_d  = 1'b0;
                tlast_d   = 1'b0;
                gap_cnt_d = gap_q;
                state_d   = ST_GAP;
              end
            end
          end else begin
            beat_d  = beat_q + 8'd1;
            tlast_d = ((beat_q + 8'd1) == len_q);
          end
        end
      end

      ST_GAP: begin
        // terminal count at one so the idle stretch is exactly gap_q cycles
        if (gap_cnt_q == 4'd1) begin
          gap_cnt_d = 4'd0;
          tvalid_d  = 1'b1;
          tlast_d   = (len_q == 8'd1);
          state_d   = ST_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign axis.tdata  = tdata_q;
  assign axis.tvalid = tvalid_q;
  assign axis.tlast  = tlast_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pkt_count   = pkt_count_q;

endmodule
